safe_ctrl: RTL and testbench



---
 rtl/safe_pkg.sv | 24 ++
 rtl/safe_ctrl_if.sv | 26 ++
 rtl/safe_timer.sv | 27 ++
 rtl/safe_ctrl.sv | 145 ++++++++++++++
 tb/tb_safe_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/safe_pkg.sv
// Shared types and constants for the safe-lock sequencing controller.
package safe_pkg;

  // Width of the comparator code-slot select.
  localparam int unsigned SEL_W = 2;

  // Number of code slots in a sequence; shared with the digit comparator.
  localparam int unsigned NUM_CODES = 3;

  typedef enum logic [1:0] {
    StEntry,
    StOpen,
    StError,
    StLockout
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/safe_ctrl_if.sv
// User/comparator side signals of the safe-lock controller.
interface safe_ctrl_if;
  import safe_pkg::*;

  logic             enter;
  logic             eq;
  logic             lock_cmd;
  logic [SEL_W-1:0] sel;
  logic             unlocked;
  logic             err;
  logic             locked_out;
  logic [1:0]       fail_cnt;

  // Controller side.
  modport slave (
    input  enter, eq, lock_cmd,
    output sel, unlocked, err, locked_out, fail_cnt
  );

  // Keypad / comparator / status side.
  modport master (
    output enter, eq, lock_cmd,
    input  sel, unlocked, err, locked_out, fail_cnt
  );

endinterface

// File: rtl/safe_timer.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module safe_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/safe_ctrl.sv
// Safe-lock sequencing controller: steps the comparator slot select, collects
// match results over a full sequence and decides open / error / lockout.
module safe_ctrl
  import safe_pkg::*;
#(
  parameter int unsigned N_CODES        = NUM_CODES,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned OPEN_CYCLES    = 1000000,
  parameter int unsigned ERR_CYCLES     = 500000,
  parameter int unsigned LOCKOUT_CYCLES = 5000000
) (
  input logic        clk,
  input logic        rst_n,
  safe_ctrl_if.slave bus
);

  localparam int unsigned MAX_CYC = max3(OPEN_CYCLES, ERR_CYCLES, LOCKOUT_CYCLES);
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]    OPEN_LD   = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]    ERR_LD    = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0]    LOCK_LD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(N_CODES - 1);
  localparam logic [1:0]       FAIL_MAX  = 2'(MAX_FAIL);
  localparam logic [1:0]       FAIL_TRIP = 2'(MAX_FAIL - 1);

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic             bad_q;
  logic [1:0]       fail_q;
  logic             unlocked_q;
  logic             err_q;
  logic             locked_out_q;

  logic             accept;
  logic             last_slot;
  logic             bad_next;
  logic             fail_hit;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;

  // Decide the sequence outcome and the matching timer load value.
  always_comb begin
    accept    = (state_q == StEntry) && bus.enter && !bus.lock_cmd;
    last_slot = (sel_q == LAST_SEL);
    bad_next  = bad_q | ~bus.eq;
    fail_hit  = (fail_q == FAIL_TRIP);
    tmr_load  = 1'b0;
    tmr_val   = '0;
    if (accept && last_slot) begin
      tmr_load = 1'b1;
      if (!bad_next) begin
        tmr_val = OPEN_LD;
      end else if (fail_hit) begin
        tmr_val = LOCK_LD;
      end else begin
        tmr_val = ERR_LD;
      end
    end
  end

  safe_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Main FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEntry;
      sel_q        <= '0;
      bad_q        <= 1'b0;
      fail_q       <= '0;
      unlocked_q   <= 1'b0;
      err_q        <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      case (state_q)
        StEntry: begin
          if (bus.lock_cmd) begin
            // Abort wins over a coincident enter.
            sel_q <= '0;
            bad_q <= 1'b0;
          end else if (bus.enter) begin
            if (!last_slot) begin
              // Mismatches are only remembered, never revealed mid-sequence.
              sel_q <= sel_q + 1'b1;
              bad_q <= bad_next;
            end else begin
              sel_q <= '0;
              bad_q <= 1'b0;
              if (!bad_next) begin
                state_q    <= StOpen;
                unlocked_q <= 1'b1;
                fail_q     <= '0;
              end else if (fail_hit) begin
                state_q      <= StLockout;
                locked_out_q <= 1'b1;
                fail_q       <= FAIL_MAX;
              end else begin
                state_q <= StError;
                err_q   <= 1'b1;
                fail_q  <= fail_q + 2'd1;
              end
            end
          end
        end
        StOpen: begin
          if (bus.lock_cmd || tmr_zero) begin
            state_q    <= StEntry;
            unlocked_q <= 1'b0;
          end
        end
        StError: begin
          if (tmr_zero) begin
            state_q <= StEntry;
            err_q   <= 1'b0;
            sel_q   <= '0;
          end
        end
        StLockout: begin
          if (tmr_zero) begin
            state_q      <= StEntry;
            locked_out_q <= 1'b0;
            fail_q       <= '0;
          end
        end
        default: state_q <= StEntry;
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.err        = err_q;
  assign bus.locked_out = locked_out_q;
  assign bus.fail_cnt   = fail_q;

endmodule

// File: tb/tb_safe_ctrl.sv
// Scoreboard bench for safe_ctrl: directed scenarios plus random traffic,
// checked against a sequence-level model of the lock.
module tb_safe_ctrl;
  import safe_pkg::*;

  localparam int unsigned OPEN_C = 8;
  localparam int unsigned ERR_C  = 4;
  localparam int unsigned LOCK_C = 16;
  localparam int unsigned NFAIL  = 3;
  localparam logic [7:0]  WRONG  = 8'h99;

  typedef struct packed {
    logic [1:0] sel;
    logic       unlocked;
    logic       err;
    logic       locked_out;
    logic [1:0] fail_cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] digit = 8'h00;

  always #5 clk = ~clk;

  safe_ctrl_if bus ();

  safe_ctrl #(
    .N_CODES        (3),
    .MAX_FAIL       (NFAIL),
    .OPEN_CYCLES    (OPEN_C),
    .ERR_CYCLES     (ERR_C),
    .LOCKOUT_CYCLES (LOCK_C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] code_of(input int slot);
    case (slot)
      0:       return 8'h10;
      1:       return 8'h05;
      2:       return 8'h15;
      default: return 8'hEE;
    endcase
  endfunction

  // Comparator stand-in: match of the entered digits against the selected slot.
  assign bus.eq = (digit == code_of(int'(bus.sel)));

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  // Reference model: 0 entry, 1 open, 2 error, 3 lockout.
  int         m_mode;
  int         m_remain;
  int         m_fails;
  logic [7:0] m_entries[$];

  task automatic model_reset();
    m_mode = 0;
    m_remain = 0;
    m_fails = 0;
    m_entries.delete();
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.sel        = (m_mode == 0) ? 2'(m_entries.size()) : 2'd0;
    o.unlocked   = (m_mode == 1);
    o.err        = (m_mode == 2);
    o.locked_out = (m_mode == 3);
    o.fail_cnt   = 2'(m_fails);
    return o;
  endfunction

  task automatic model_step(input bit en, input bit lk, input logic [7:0] dg);
    bit ok;
    case (m_mode)
      0: begin
        if (lk) begin
          m_entries.delete();
        end else if (en) begin
          m_entries.push_back(dg);
          if (m_entries.size() == 3) begin
            ok = 1'b1;
            for (int i = 0; i < 3; i++) if (m_entries[i] != code_of(i)) ok = 1'b0;
            m_entries.delete();
            if (ok) begin
              m_mode = 1; m_remain = OPEN_C; m_fails = 0;
            end else if (m_fails + 1 == NFAIL) begin
              m_mode = 3; m_remain = LOCK_C; m_fails = NFAIL;
            end else begin
              m_mode = 2; m_remain = ERR_C; m_fails = m_fails + 1;
            end
          end
        end
      end
      1: begin
        if (lk || m_remain == 1) m_mode = 0;
        else m_remain--;
      end
      default: begin
        if (m_remain == 1) begin
          if (m_mode == 3) m_fails = 0;
          m_mode = 0;
        end else begin
          m_remain--;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cycle(input bit en, input bit lk, input logic [7:0] dg);
    @(negedge clk);
    bus.enter    = en;
    bus.lock_cmd = lk;
    digit        = dg;
    model_step(en, lk, dg);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    cycle(1'b1, 1'b0, a);
    cycle(1'b1, 1'b0, b);
    cycle(1'b1, 1'b0, c);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.sel        = bus.sel;
    o.unlocked   = bus.unlocked;
    o.err        = bus.err;
    o.locked_out = bus.locked_out;
    o.fail_cnt   = bus.fail_cnt;
    return o;
  endfunction

  task automatic check_zero(input string name);
    obs_t g;
    g = sample();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL %s t=%0t got sel=%0d unl=%0b err=%0b lo=%0b fc=%0d want all 0",
               name, $time, g.sel, g.unlocked, g.err, g.locked_out, g.fail_cnt);
    end
  endtask

  // Assert reset between edges and confirm outputs clear without a clock edge.
  task automatic reset_check(input string name);
    @(posedge clk);
    #3;
    rst_n        = 1'b0;
    bus.enter    = 1'b0;
    bus.lock_cmd = 1'b0;
    #1;
    check_zero(name);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compare every queued expectation just after the active edge.
  always @(posedge clk) begin
    obs_t e;
    obs_t g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle t=%0t got sel=%0d unl=%0b err=%0b lo=%0b fc=%0d want sel=%0d unl=%0b err=%0b lo=%0b fc=%0d",
                 $time, g.sel, g.unlocked, g.err, g.locked_out, g.fail_cnt,
                 e.sel, e.unlocked, e.err, e.locked_out, e.fail_cnt);
      end
    end
  end

  initial begin
    bus.enter    = 1'b0;
    bus.lock_cmd = 1'b0;
    model_reset();
    #12;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Correct code opens for the full open window.
    seq(8'h10, 8'h05, 8'h15);
    idle(10);

    // Wrong middle digit: error only after the final entry.
    seq(8'h10, WRONG, 8'h15);
    idle(6);

    // Two more failures: error, then lockout with enter pulses ignored.
    seq(WRONG, 8'h05, 8'h15);
    idle(6);
    seq(8'h10, 8'h05, WRONG);
    for (int i = 0; i < 18; i++) cycle(i[0], 1'b0, 8'h10);
    idle(2);

    // Early close, then close coinciding with expiry.
    seq(8'h10, 8'h05, 8'h15);
    idle(2);
    cycle(1'b0, 1'b1, 8'h00);
    idle(3);
    seq(8'h10, 8'h05, 8'h15);
    idle(7);
    cycle(1'b0, 1'b1, 8'h00);
    idle(3);

    // Abort with coincident enter, then a correct sequence.
    cycle(1'b1, 1'b0, 8'h10);
    cycle(1'b1, 1'b1, 8'h05);
    seq(8'h10, 8'h05, 8'h15);
    idle(9);

    // Asynchronous reset mid-error and mid-open.
    seq(WRONG, WRONG, WRONG);
    idle(1);
    reset_check("reset_mid_error");
    seq(8'h10, 8'h05, 8'h15);
    idle(2);
    reset_check("reset_mid_open");

    // Random traffic biased towards correct digits.
    for (int i = 0; i < 3000; i++) begin
      bit         en;
      bit         lk;
      logic [7:0] dg;
      en = ($urandom_range(2) == 0);
      lk = ($urandom_range(24) == 0);
      dg = ($urandom_range(4) == 0) ? WRONG : code_of(m_entries.size());
      cycle(en, lk, dg);
    end
    idle(2);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
